// File: rtl/demux1x4_stream.sv
// Registered 1-to-4 stream demultiplexer.
// One input word is steered by {S1_i,S0_i} into one of four single-entry
// lane registers; each lane has an independent valid/ready handshake so a
// stalled consumer never blocks the other lanes.
module demux1x4_stream #(
    parameter int width = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [width-1:0] A_i,
    input  logic             S0_i,
    input  logic             S1_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [width-1:0] Y0_o,
    output logic [width-1:0] Y1_o,
    output logic [width-1:0] Y2_o,
    output logic [width-1:0] Y3_o,
    output logic             valid0_o,
    output logic             valid1_o,
    output logic             valid2_o,
    output logic             valid3_o,
    input  logic             ready0_i,
    input  logic             ready1_i,
    input  logic             ready2_i,
    input  logic             ready3_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [1:0]       sel;
    logic [3:0]       lane_rdy;
    logic             accept;

    logic [width-1:0] y_q [4];
    logic [width-1:0] y_d [4];
    logic [3:0]       v_q;
    logic [3:0]       v_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sel      = {S1_i, S0_i};
    assign lane_rdy = {ready3_i, ready2_i, ready1_i, ready0_i};

    // Selected lane can take a word if it is empty or being drained this cycle.
    assign ready_o = !rst_i && (!v_q[sel] || lane_rdy[sel]);
    assign accept  = valid_i && ready_o;

    // Next state: drain every lane whose consumer takes it, then load the
    // selected lane on accept (a load overrides a same-cycle drain).
    always_comb begin
        y_d   = y_q;
        v_d   = v_q & ~lane_rdy;
        cnt_d = cnt_q;
        if (accept) begin
            y_d[sel] = A_i;
            v_d[sel] = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset discarding any held words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign Y0_o     = y_q[0];
    assign Y1_o     = y_q[1];
    assign Y2_o     = y_q[2];
    assign Y3_o     = y_q[3];
    assign valid0_o = v_q[0];
    assign valid1_o = v_q[1];
    assign valid2_o = v_q[2];
    assign valid3_o = v_q[3];
    assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_demux1x4_stream.sv
// Self-checking bench for demux1x4_stream: directed scenarios followed by a
// random soak, all compared against a per-lane queue model.
module tb_demux1x4_stream;

    localparam int W  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [W-1:0]  A_i;
    logic          S0_i, S1_i, valid_i;
    logic          ready_o;
    logic [W-1:0]  Y0_o, Y1_o, Y2_o, Y3_o;
    logic          valid0_o, valid1_o, valid2_o, valid3_o;
    logic          ready0_i, ready1_i, ready2_i, ready3_i;
    logic [CW-1:0] cnt_o;

    logic [W-1:0]  yo [4];
    logic [3:0]    vo;

    int checks   = 0;
    int failures = 0;

    // Reference model: each lane is a queue of pending words.
    logic [W-1:0]  lane_q [4][$];
    logic [W-1:0]  last_y [4];
    int            mdl_cnt;

    always #5 clk = ~clk;

    demux1x4_stream #(.width(W), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .A_i(A_i), .S0_i(S0_i), .S1_i(S1_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .Y0_o(Y0_o), .Y1_o(Y1_o), .Y2_o(Y2_o), .Y3_o(Y3_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o), .valid3_o(valid3_o),
        .ready0_i(ready0_i), .ready1_i(ready1_i), .ready2_i(ready2_i), .ready3_i(ready3_i),
        .cnt_o(cnt_o)
    );

    assign yo[0] = Y0_o;
    assign yo[1] = Y1_o;
    assign yo[2] = Y2_o;
    assign yo[3] = Y3_o;
    assign vo    = {valid3_o, valid2_o, valid1_o, valid0_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready_o and drained data mid-cycle,
    // advance the model, then check registered outputs just after the edge.
    task automatic cycle(input logic r, input logic [W-1:0] a, input logic [1:0] s,
                         input logic v, input logic [3:0] rd);
        logic exp_rdy;
        rst_i = r; A_i = a; {S1_i, S0_i} = s; valid_i = v;
        {ready3_i, ready2_i, ready1_i, ready0_i} = rd;
        @(negedge clk);
        exp_rdy = !r && (lane_q[s].size() == 0 || rd[s]);
        chk("ready_o", 32'(ready_o), 32'(exp_rdy));
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                lane_q[k].delete();
                last_y[k] = '0;
            end
            mdl_cnt = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (rd[k] && lane_q[k].size() != 0) begin
                    chk($sformatf("drainY%0d", k), 32'(yo[k]), 32'(lane_q[k][0]));
                    void'(lane_q[k].pop_front());
                end
            end
            if (v && exp_rdy) begin
                lane_q[s].push_back(a);
                last_y[s] = a;
                mdl_cnt = (mdl_cnt + 1) % (1 << CW);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), 32'(vo[k]), 32'(lane_q[k].size() != 0));
            chk($sformatf("Y%0d", k), 32'(yo[k]), 32'(last_y[k]));
        end
        chk("cnt_o", 32'(cnt_o), 32'(mdl_cnt));
    endtask

    initial begin
        logic [W-1:0] words [4];
        rst_i = 1'b1; A_i = '0; S0_i = 1'b0; S1_i = 1'b0; valid_i = 1'b0;
        ready0_i = 1'b0; ready1_i = 1'b0; ready2_i = 1'b0; ready3_i = 1'b0;
        mdl_cnt = 0;
        for (int k = 0; k < 4; k++) last_y[k] = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then idle with ready expected high.
        cycle(1'b1, 4'hF, 2'd0, 1'b1, 4'h0);
        cycle(1'b1, 4'hF, 2'd0, 1'b1, 4'h0);
        cycle(1'b0, 4'h0, 2'd0, 1'b0, 4'h0);

        // Fan-out to all four lanes.
        words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'h9; words[3] = 4'hC;
        for (int k = 0; k < 4; k++) cycle(1'b0, words[k], 2'(k), 1'b1, 4'h0);
        chk("fan_Y0", 32'(Y0_o), 32'h3);
        chk("fan_Y3", 32'(Y3_o), 32'hC);
        chk("fan_cnt", 32'(cnt_o), 32'd4);

        // Backpressure: free lane1, lane2 blocked, redirect to lane1, drain lane2.
        cycle(1'b0, 4'h0, 2'd1, 1'b0, 4'b0010);
        cycle(1'b0, 4'h7, 2'd2, 1'b1, 4'h0);
        chk("bp_Y2", 32'(Y2_o), 32'h9);
        cycle(1'b0, 4'h7, 2'd1, 1'b1, 4'h0);
        chk("bp_Y1", 32'(Y1_o), 32'h7);
        cycle(1'b0, 4'h0, 2'd0, 1'b0, 4'b0100);
        chk("bp_v2", 32'(valid2_o), 32'd0);

        // Streaming into lane3 with its consumer always ready.
        for (int i = 1; i <= 4; i++) cycle(1'b0, 4'(i), 2'd3, 1'b1, 4'b1000);
        chk("str_Y3", 32'(Y3_o), 32'h4);

        // Mid-operation reset with lanes full and valid_i high.
        cycle(1'b0, 4'hA, 2'd0, 1'b1, 4'hF);
        cycle(1'b0, 4'hB, 2'd1, 1'b1, 4'h0);
        cycle(1'b1, 4'hD, 2'd2, 1'b1, 4'h0);
        cycle(1'b0, 4'h0, 2'd0, 1'b0, 4'hF);
        chk("rst_v", 32'(vo), 32'd0);

        // Counter wrap: 17 accepts from reset into always-ready lanes.
        cycle(1'b1, 4'h0, 2'd0, 1'b0, 4'h0);
        for (int i = 0; i < 17; i++)
            cycle(1'b0, 4'($urandom), 2'($urandom), 1'b1, 4'hF);
        chk("wrap_cnt", 32'(cnt_o), 32'd1);

        // Random soak with occasional reset.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 199) == 0), 4'($urandom), 2'($urandom),
                  1'($urandom), 4'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
